// File: rtl/retire_rat.sv
// retire_rat: retirement register alias table for the out-of-order RV32I core.
// Holds the committed arch->phys mapping. Each committing instruction with a
// destination frees the previously committed physical register to the free
// list. On a branch mispredict the committed mapping is walked back into the
// front-end rename RAT, one entry per cycle, while commit is held off.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   commit_valid/rd/pd   ROB head commit (accepted when commit_ready)
//   commit_ready         high in IDLE, low while recovering
//   branch_mispredict    single-cycle flush pulse
//   free_enqueue/wdata   registered free-list enqueue, one cycle after commit
//   restore_valid/idx/pd front-end RAT write during recovery walk
//   recovering           recovery walk in progress
//   restore_done         pulse coinciding with the final restore write (idx 31)
module retire_rat #(
   parameter int unsigned NUM_ARCH_REGS = 32,
   parameter int unsigned ARCH_W        = 5,
   parameter int unsigned PREG_W        = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              commit_valid,
   input  logic [ARCH_W-1:0] commit_rd,
   input  logic [PREG_W-1:0] commit_pd,
   output logic              commit_ready,
   input  logic              branch_mispredict,
   output logic              free_enqueue,
   output logic [PREG_W-1:0] free_wdata,
   output logic              restore_valid,
   output logic [ARCH_W-1:0] restore_idx,
   output logic [PREG_W-1:0] restore_pd,
   output logic              recovering,
   output logic              restore_done
);

   localparam logic [ARCH_W-1:0] FIRST_IDX = ARCH_W'(1);
   localparam logic [ARCH_W-1:0] LAST_IDX  = ARCH_W'(NUM_ARCH_REGS - 1);

   typedef enum logic {IDLE, RECOVER} state_t;

   state_t            state;
   logic [ARCH_W-1:0] walk_idx;
   logic [PREG_W-1:0] rrat [NUM_ARCH_REGS];

   logic commit_fire;
   logic commit_writes;

   // Commits are only accepted in IDLE; x0 never updates the table.
   assign commit_fire   = commit_valid && (state == IDLE);
   assign commit_writes = commit_fire && (commit_rd != '0);

   // Status and restore outputs decode directly from registered state, counter
   // and table, so restore_pd always reflects the committed mapping.
   assign commit_ready  = (state == IDLE);
   assign recovering    = (state == RECOVER);
   assign restore_valid = recovering;
   assign restore_idx   = recovering ? walk_idx : '0;
   assign restore_pd    = recovering ? rrat[walk_idx] : '0;
   assign restore_done  = recovering && (walk_idx == LAST_IDX);

   // Table update, free-list enqueue and recovery walk sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         walk_idx     <= '0;
         free_enqueue <= 1'b0;
         free_wdata   <= '0;
         for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
            rrat[i] <= PREG_W'(i);
         end
      end else begin
         free_enqueue <= 1'b0;

         // Old mapping is read before the write lands; the free list's own
         // full restore reclaims the register on a same-cycle mispredict.
         if (commit_writes) begin
            rrat[commit_rd] <= commit_pd;
            if (!branch_mispredict) begin
               free_enqueue <= 1'b1;
               free_wdata   <= rrat[commit_rd];
            end
         end

         case (state)
            IDLE: begin
               if (branch_mispredict) begin
                  state    <= RECOVER;
                  walk_idx <= FIRST_IDX;
               end
            end
            RECOVER: begin
               if (branch_mispredict) begin
                  walk_idx <= FIRST_IDX;
               end else if (walk_idx == LAST_IDX) begin
                  state    <= IDLE;
                  walk_idx <= '0;
               end else begin
                  walk_idx <= walk_idx + ARCH_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               walk_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_retire_rat.sv
// tb_retire_rat: directed self-checking bench for retire_rat.
module tb_retire_rat;

   logic       clk = 1'b0;
   logic       rst;
   logic       commit_valid;
   logic [4:0] commit_rd;
   logic [5:0] commit_pd;
   logic       commit_ready;
   logic       branch_mispredict;
   logic       free_enqueue;
   logic [5:0] free_wdata;
   logic       restore_valid;
   logic [4:0] restore_idx;
   logic [5:0] restore_pd;
   logic       recovering;
   logic       restore_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] exp_rrat [32];

   retire_rat dut (
      .clk               (clk),
      .rst               (rst),
      .commit_valid      (commit_valid),
      .commit_rd         (commit_rd),
      .commit_pd         (commit_pd),
      .commit_ready      (commit_ready),
      .branch_mispredict (branch_mispredict),
      .free_enqueue      (free_enqueue),
      .free_wdata        (free_wdata),
      .restore_valid     (restore_valid),
      .restore_idx       (restore_idx),
      .restore_pd        (restore_pd),
      .recovering        (recovering),
      .restore_done      (restore_done)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) exp_rrat[i] = 6'(i);
   endtask

   task automatic test_reset();
      rst = 1'b1; commit_valid = 1'b0; commit_rd = '0; commit_pd = '0; branch_mispredict = 1'b0;
      tick(); tick();
      rst = 1'b0;
      model_reset();
      n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL reset_free_enqueue: got %0b expected 0", free_enqueue); end
      n_checks++; if (free_wdata !== 6'd0) begin n_fail++; $display("FAIL reset_free_wdata: got %0d expected 0", free_wdata); end
      n_checks++; if (restore_valid !== 1'b0) begin n_fail++; $display("FAIL reset_restore_valid: got %0b expected 0", restore_valid); end
      n_checks++; if (restore_idx !== 5'd0) begin n_fail++; $display("FAIL reset_restore_idx: got %0d expected 0", restore_idx); end
      n_checks++; if (restore_pd !== 6'd0) begin n_fail++; $display("FAIL reset_restore_pd: got %0d expected 0", restore_pd); end
      n_checks++; if (recovering !== 1'b0) begin n_fail++; $display("FAIL reset_recovering: got %0b expected 0", recovering); end
      n_checks++; if (restore_done !== 1'b0) begin n_fail++; $display("FAIL reset_restore_done: got %0b expected 0", restore_done); end
      n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_commit_ready: got %0b expected 1", commit_ready); end
   endtask

   task automatic test_commit();
      commit_valid = 1'b1; commit_rd = 5'd5; commit_pd = 6'd40;
      tick();
      exp_rrat[5] = 6'd40;
      commit_valid = 1'b0;
      n_checks++; if (free_enqueue !== 1'b1) begin n_fail++; $display("FAIL commit_free_enqueue: got %0b expected 1", free_enqueue); end
      n_checks++; if (free_wdata !== 6'd5) begin n_fail++; $display("FAIL commit_free_wdata: got %0d expected 5", free_wdata); end
      tick();
      n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL commit_free_drop: got %0b expected 0", free_enqueue); end
   endtask

   task automatic test_x0();
      commit_valid = 1'b1; commit_rd = 5'd0; commit_pd = 6'd41;
      tick();
      commit_valid = 1'b0;
      n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL x0_free_enqueue: got %0b expected 0", free_enqueue); end
      tick();
      n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL x0_free_enqueue_next: got %0b expected 0", free_enqueue); end
   endtask

   task automatic test_back_to_back();
      commit_valid = 1'b1; commit_rd = 5'd7; commit_pd = 6'd33;
      tick();
      n_checks++; if (free_enqueue !== 1'b1) begin n_fail++; $display("FAIL b2b_first_enqueue: got %0b expected 1", free_enqueue); end
      n_checks++; if (free_wdata !== 6'd7) begin n_fail++; $display("FAIL b2b_first_wdata: got %0d expected 7", free_wdata); end
      commit_pd = 6'd34;
      tick();
      exp_rrat[7] = 6'd34;
      commit_valid = 1'b0;
      n_checks++; if (free_enqueue !== 1'b1) begin n_fail++; $display("FAIL b2b_second_enqueue: got %0b expected 1", free_enqueue); end
      n_checks++; if (free_wdata !== 6'd33) begin n_fail++; $display("FAIL b2b_second_wdata: got %0d expected 33", free_wdata); end
      tick();
      n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %0b expected 0", free_enqueue); end
   endtask

   task automatic test_mispredict();
      logic       exp_done;
      logic [4:0] exp_idx;
      commit_valid = 1'b1; commit_rd = 5'd10; commit_pd = 6'd45;
      tick();
      exp_rrat[10] = 6'd45;
      // Mispredict with a same-cycle commit; the prior cycle's free is still driven now.
      commit_rd = 5'd3; commit_pd = 6'd50; branch_mispredict = 1'b1;
      n_checks++; if (free_enqueue !== 1'b1) begin n_fail++; $display("FAIL mp_prior_free_enqueue: got %0b expected 1", free_enqueue); end
      n_checks++; if (free_wdata !== 6'd10) begin n_fail++; $display("FAIL mp_prior_free_wdata: got %0d expected 10", free_wdata); end
      n_checks++; if (recovering !== 1'b0) begin n_fail++; $display("FAIL mp_cycle_recovering: got %0b expected 0", recovering); end
      tick();
      exp_rrat[3] = 6'd50;
      branch_mispredict = 1'b0; commit_valid = 1'b0;
      for (int k = 1; k < 32; k++) begin
         exp_idx  = 5'(k);
         exp_done = (k == 31);
         n_checks++; if (restore_valid !== 1'b1) begin n_fail++; $display("FAIL mp_walk_valid k=%0d: got %0b expected 1", k, restore_valid); end
         n_checks++; if (restore_idx !== exp_idx) begin n_fail++; $display("FAIL mp_walk_idx k=%0d: got %0d expected %0d", k, restore_idx, exp_idx); end
         n_checks++; if (restore_pd !== exp_rrat[k]) begin n_fail++; $display("FAIL mp_walk_pd k=%0d: got %0d expected %0d", k, restore_pd, exp_rrat[k]); end
         n_checks++; if (restore_done !== exp_done) begin n_fail++; $display("FAIL mp_walk_done k=%0d: got %0b expected %0b", k, restore_done, exp_done); end
         n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL mp_walk_ready k=%0d: got %0b expected 0", k, commit_ready); end
         n_checks++; if (recovering !== 1'b1) begin n_fail++; $display("FAIL mp_walk_recovering k=%0d: got %0b expected 1", k, recovering); end
         n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL mp_walk_free k=%0d: got %0b expected 0", k, free_enqueue); end
         tick();
      end
      n_checks++; if (recovering !== 1'b0) begin n_fail++; $display("FAIL mp_end_recovering: got %0b expected 0", recovering); end
      n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL mp_end_ready: got %0b expected 1", commit_ready); end
      n_checks++; if (restore_valid !== 1'b0) begin n_fail++; $display("FAIL mp_end_valid: got %0b expected 0", restore_valid); end
      n_checks++; if (restore_done !== 1'b0) begin n_fail++; $display("FAIL mp_end_done: got %0b expected 0", restore_done); end
   endtask

   task automatic test_recover_commit();
      logic [4:0] exp_idx;
      branch_mispredict = 1'b1;
      tick();
      branch_mispredict = 1'b0;
      // Commit held valid for the whole recovery must be ignored.
      commit_valid = 1'b1; commit_rd = 5'd9; commit_pd = 6'd60;
      for (int k = 1; k <= 12; k++) begin
         exp_idx = 5'(k);
         n_checks++; if (restore_idx !== exp_idx) begin n_fail++; $display("FAIL rc_pre_idx k=%0d: got %0d expected %0d", k, restore_idx, exp_idx); end
         n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL rc_pre_free k=%0d: got %0b expected 0", k, free_enqueue); end
         if (k == 12) branch_mispredict = 1'b1;
         tick();
      end
      branch_mispredict = 1'b0;
      for (int k = 1; k < 32; k++) begin
         exp_idx = 5'(k);
         n_checks++; if (restore_idx !== exp_idx) begin n_fail++; $display("FAIL rc_restart_idx k=%0d: got %0d expected %0d", k, restore_idx, exp_idx); end
         n_checks++; if (restore_pd !== exp_rrat[k]) begin n_fail++; $display("FAIL rc_restart_pd k=%0d: got %0d expected %0d", k, restore_pd, exp_rrat[k]); end
         n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL rc_restart_free k=%0d: got %0b expected 0", k, free_enqueue); end
         if (k == 31) commit_valid = 1'b0;
         tick();
      end
      n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL rc_end_ready: got %0b expected 1", commit_ready); end
      n_checks++; if (free_enqueue !== 1'b0) begin n_fail++; $display("FAIL rc_end_free: got %0b expected 0", free_enqueue); end
   endtask

   task automatic test_reset_mid();
      logic [4:0] exp_idx;
      branch_mispredict = 1'b1;
      tick();
      branch_mispredict = 1'b0;
      for (int k = 1; k < 20; k++) tick();
      n_checks++; if (restore_idx !== 5'd20) begin n_fail++; $display("FAIL rm_idx_before_reset: got %0d expected 20", restore_idx); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      n_checks++; if (recovering !== 1'b0) begin n_fail++; $display("FAIL rm_recovering: got %0b expected 0", recovering); end
      n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %0b expected 1", commit_ready); end
      n_checks++; if (restore_valid !== 1'b0) begin n_fail++; $display("FAIL rm_restore_valid: got %0b expected 0", restore_valid); end
      n_checks++; if (free_wdata !== 6'd0) begin n_fail++; $display("FAIL rm_free_wdata: got %0d expected 0", free_wdata); end
      // Walk again to confirm the table returned to identity.
      branch_mispredict = 1'b1;
      tick();
      branch_mispredict = 1'b0;
      for (int k = 1; k < 32; k++) begin
         exp_idx = 5'(k);
         n_checks++; if (restore_idx !== exp_idx) begin n_fail++; $display("FAIL rm_walk_idx k=%0d: got %0d expected %0d", k, restore_idx, exp_idx); end
         n_checks++; if (restore_pd !== exp_rrat[k]) begin n_fail++; $display("FAIL rm_walk_pd k=%0d: got %0d expected %0d", k, restore_pd, exp_rrat[k]); end
         tick();
      end
      commit_valid = 1'b1; commit_rd = 5'd5; commit_pd = 6'd44;
      tick();
      commit_valid = 1'b0;
      n_checks++; if (free_enqueue !== 1'b1) begin n_fail++; $display("FAIL rm_commit_enqueue: got %0b expected 1", free_enqueue); end
      n_checks++; if (free_wdata !== 6'd5) begin n_fail++; $display("FAIL rm_commit_wdata: got %0d expected 5", free_wdata); end
      tick();
   endtask

   initial begin
      test_reset();
      test_commit();
      test_x0();
      test_back_to_back();
      test_mispredict();
      test_recover_commit();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/retire_rat.md
Name: retire_rat

Overview:
- Retirement Register Alias Table for the out-of-order RV32I core.
- Holds the committed architectural-to-physical mapping.
- On every committing instruction with a destination, it produces the previously mapped physical register as the enqueue stream into the physical-register free list.
- On a branch mispredict, it walks its committed mapping back into the front-end rename RAT, one entry per cycle, while holding off commit.

Parameters:
- NUM_ARCH_REGS, 32, number of architectural registers (x0..x31).
- ARCH_W, 5, architectural index width.
- PREG_W, PHYS_REG_IDX + 1, physical register index width; matches the free-list data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit_valid  in  1  ROB head commits this cycle
- commit_rd  in  ARCH_W  architectural destination of the committing instruction
- commit_pd  in  PREG_W  physical register allocated to commit_rd at rename
- commit_ready  out  1  block accepts commits; low while recovering
- branch_mispredict  in  1  single-cycle pulse; ROB/free list flush this cycle
- free_enqueue  out  1  enqueue strobe to free list
- free_wdata  out  PREG_W  physical register being freed
- restore_valid  out  1  front-end RAT write strobe during recovery
- restore_idx  out  ARCH_W  architectural index being restored
- restore_pd  out  PREG_W  committed mapping for restore_idx
- recovering  out  1  recovery walk in progress; front end stalls rename
- restore_done  out  1  one-cycle pulse with the final restore write

Behaviour:
- Storage: rrat[0..31] of PREG_W bits.
- Reset: rrat[i] = i for all i, which is consistent with the free list holding 32..63 at reset.
- Reset values of outputs:
  - free_enqueue = 0, free_wdata = 0
  - restore_valid = 0, restore_idx = 0, restore_pd = 0
  - recovering = 0, restore_done = 0
  - commit_ready = 1
  - state = IDLE
- Commit in IDLE:
  - A commit is accepted when commit_valid && commit_ready.
  - If commit_rd != 0: rrat[commit_rd] <= commit_pd.
  - The old value rrat[commit_rd], read before the write, is registered into free_wdata, with free_enqueue = 1 the next cycle. Latency is exactly 1 cycle.
  - If commit_rd == 0: no rrat write and no free_enqueue. rrat[0] stays 0 forever.
  - Back-to-back commits to the same rd: the second one frees the commit_pd written by the first (write-then-read ordering across cycles; no bypass is needed because the rrat write lands before the next read).
  - At most one free per cycle. free_enqueue deasserts in any cycle following a non-freeing cycle.
- Mispredict (IDLE, branch_mispredict = 1):
  - A commit in the same cycle still updates rrat.
  - That commit does NOT generate free_enqueue next cycle, because the free list's full-restore reclaims it.
  - A free_enqueue registered from the previous cycle's commit is still driven in the mispredict cycle.
  - Next state is RECOVER with the walk counter at 1.
- RECOVER:
  - Each cycle drives restore_valid = 1, restore_idx = counter, restore_pd = rrat[counter], then the counter increments.
  - Indices 1..31 are walked in order; x0 is never restored.
  - Recovery lasts 31 cycles, with recovering = 1 and commit_ready = 0 throughout.
  - restore_done = 1 coincides with restore_idx = 31.
  - The cycle after that returns to IDLE: recovering = 0, commit_ready = 1.
  - The restore outputs are combinational from the state, the counter and rrat, so restore_pd always reflects committed state.
- Commits during RECOVER: commit_valid is ignored (no rrat write, no free).
- branch_mispredict during RECOVER: the walk restarts at index 1 next cycle.
- Reset mid-operation: rrat, state, counter and all outputs return to reset values next cycle.
- Width rules: no arithmetic on PREG_W data. The counter is ARCH_W bits and saturates to IDLE after 31, with no wrap to 0.

Test Plan:
- Reset, then commit rd=5, pd=40 → next cycle free_enqueue=1, free_wdata=5; rrat[5]=40.
- Commit rd=0, pd=41 → free_enqueue stays 0; rrat[0] remains 0.
- Back-to-back commits rd=7 pd=33, then rd=7 pd=34 → frees 7 then 33 on consecutive cycles; rrat[7]=34.
- Commit rd=3 pd=50 with branch_mispredict in the same cycle → no free for 3; the walk starts next cycle; restore_idx=3 cycle shows restore_pd=50; restore_done fires at idx 31, 31 cycles after the start; commit_ready low throughout.
- Commit held valid during RECOVER with rd=9 pd=60 → rrat[9] unchanged and no free_enqueue; a second mispredict at idx 12 → the walk restarts at idx 1.
- Assert rst at walk idx 20 → next cycle recovering=0, commit_ready=1, rrat[i]=i.
